// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and writeback unit: big-endian load extraction,
// result select, GPR write port and retired-instruction counter. Optional WB_BYPASS_EN.
module mem_wb_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic            m_valid,
    input  logic            m_regwrite,
    input  logic            m_memtoreg,
    input  logic            m_link,
    input  logic [2:0]      m_load_type,
    input  logic [1:0]      m_addr_lo,
    input  logic [4:0]      m_wa,
    input  logic [XLEN-1:0] m_alu_result,
    input  logic [XLEN-1:0] m_mem_rdata,
    input  logic [XLEN-1:0] m_pc_plus8,
`ifdef WB_BYPASS_EN
    input  logic [4:0]      d_ra1,
    input  logic [4:0]      d_ra2,
    input  logic [XLEN-1:0] d_rd1_raw,
    input  logic [XLEN-1:0] d_rd2_raw,
    output logic [XLEN-1:0] d_rd1,
    output logic [XLEN-1:0] d_rd2,
`endif
    output logic            rf_we,
    output logic [4:0]      rf_wa,
    output logic [XLEN-1:0] rf_wd,
    output logic            wb_valid,
    output logic [31:0]     retired_count
);

    localparam logic [2:0] LT_LW  = 3'd0;
    localparam logic [2:0] LT_LB  = 3'd1;
    localparam logic [2:0] LT_LBU = 3'd2;
    localparam logic [2:0] LT_LH  = 3'd3;
    localparam logic [2:0] LT_LHU = 3'd4;

    logic            r_valid;
    logic            r_regwrite;
    logic            r_memtoreg;
    logic            r_link;
    logic [2:0]      r_load_type;
    logic [1:0]      r_addr_lo;
    logic [4:0]      r_wa;
    logic [XLEN-1:0] r_alu_result;
    logic [XLEN-1:0] r_mem_rdata;
    logic [XLEN-1:0] r_pc_plus8;
    logic [31:0]     r_retired_count;

    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [XLEN-1:0] w_load_data;
    logic [XLEN-1:0] w_rf_wd;
    logic            w_rf_we;

    // Stage register: every field is cleared on reset so all outputs read 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid      <= 1'b0;
            r_regwrite   <= 1'b0;
            r_memtoreg   <= 1'b0;
            r_link       <= 1'b0;
            r_load_type  <= 3'd0;
            r_addr_lo    <= 2'd0;
            r_wa         <= 5'd0;
            r_alu_result <= '0;
            r_mem_rdata  <= '0;
            r_pc_plus8   <= '0;
        end else if (flush_i) begin
            r_valid <= 1'b0;
        end else if (!stall_i) begin
            r_valid      <= m_valid;
            r_regwrite   <= m_regwrite;
            r_memtoreg   <= m_memtoreg;
            r_link       <= m_link;
            r_load_type  <= m_load_type;
            r_addr_lo    <= m_addr_lo;
            r_wa         <= m_wa;
            r_alu_result <= m_alu_result;
            r_mem_rdata  <= m_mem_rdata;
            r_pc_plus8   <= m_pc_plus8;
        end
    end

    // A held (stalled) entry is presented again but retires only once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_retired_count <= 32'd0;
        end else if (r_valid && !stall_i) begin
            r_retired_count <= r_retired_count + 32'd1;
        end
    end

    always_comb begin
        w_byte = r_mem_rdata[7:0];
        case (r_addr_lo)
            2'd0:    w_byte = r_mem_rdata[31:24];
            2'd1:    w_byte = r_mem_rdata[23:16];
            2'd2:    w_byte = r_mem_rdata[15:8];
            default: w_byte = r_mem_rdata[7:0];
        endcase
        w_half = r_addr_lo[1] ? r_mem_rdata[15:0] : r_mem_rdata[31:16];
    end

    always_comb begin
        w_load_data = r_mem_rdata;
        case (r_load_type)
            LT_LB:   w_load_data = {{24{w_byte[7]}}, w_byte};
            LT_LBU:  w_load_data = {24'd0, w_byte};
            LT_LH:   w_load_data = {{16{w_half[15]}}, w_half};
            LT_LHU:  w_load_data = {16'd0, w_half};
            LT_LW:   w_load_data = r_mem_rdata;
            default: w_load_data = r_mem_rdata;
        endcase
    end

    always_comb begin
        w_rf_wd = r_alu_result;
        if (r_link) begin
            w_rf_wd = r_pc_plus8;
        end else if (r_memtoreg) begin
            w_rf_wd = w_load_data;
        end
    end

    assign w_rf_we       = r_valid & r_regwrite & (r_wa != 5'd0);
    assign rf_we         = w_rf_we;
    assign rf_wa         = r_wa;
    assign rf_wd         = w_rf_wd;
    assign wb_valid      = r_valid;
    assign retired_count = r_retired_count;

`ifdef WB_BYPASS_EN
    // Same-cycle write-before-read for the decode-stage operand reads.
    assign d_rd1 = (w_rf_we && (d_ra1 == r_wa)) ? w_rf_wd : d_rd1_raw;
    assign d_rd2 = (w_rf_we && (d_ra2 == r_wa)) ? w_rf_wd : d_rd2_raw;
`endif

endmodule
